// File: rtl/fpu_sequencer.sv
// fpu_sequencer
// Request/response sequencer placed directly in front of the FPU datapath.
// It accepts one operation over a valid/ready handshake and holds funct and
// operands stable on the FPU inputs. Add, sub and mul are timed by a fixed
// latency. Divide is timed by the divider done flag, with a timeout. The
// result is captured into a register and returned over a second valid/ready
// handshake.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake
//   req_funct               0 add, 1 sub, 2 div, 3 mul
//   req_a, req_b            single-precision operands
//   fpu_funct/fpu_a/fpu_b   registered operation driven into the FPU
//   fpu_o                   FPU result
//   fpu_div_done            divider finish flag
//   rsp_valid/rsp_ready     response handshake
//   rsp_data                captured result (quiet NaN on timeout)
//   rsp_funct               funct of the captured operation
//   rsp_timeout             divider timed out
module fpu_sequencer #(
  parameter int unsigned ADD_LAT     = 2,
  parameter int unsigned MUL_LAT     = 2,
  parameter int unsigned DIV_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_funct,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [1:0]  fpu_funct,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic [31:0] fpu_o,
  input  logic        fpu_div_done,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_funct,
  output logic        rsp_timeout
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [7:0]  ADD_INIT = 8'(ADD_LAT - 1);
  localparam logic [7:0]  MUL_INIT = 8'(MUL_LAT - 1);
  localparam logic [7:0]  DIV_LAST = 8'(DIV_TIMEOUT - 1);
  localparam logic [31:0] QNAN     = 32'h7FC00000;
  localparam logic [1:0]  F_DIV    = 2'd2;
  localparam logic [1:0]  F_MUL    = 2'd3;

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic [1:0]  fpu_funct_nx;
  logic [31:0] fpu_a_nx, fpu_b_nx;
  logic [31:0] rsp_data_nx;
  logic [1:0]  rsp_funct_nx;
  logic        rsp_timeout_nx;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      fpu_funct   <= '0;
      fpu_a       <= '0;
      fpu_b       <= '0;
      rsp_data    <= '0;
      rsp_funct   <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      fpu_funct   <= fpu_funct_nx;
      fpu_a       <= fpu_a_nx;
      fpu_b       <= fpu_b_nx;
      rsp_data    <= rsp_data_nx;
      rsp_funct   <= rsp_funct_nx;
      rsp_timeout <= rsp_timeout_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    fpu_funct_nx   = fpu_funct;
    fpu_a_nx       = fpu_a;
    fpu_b_nx       = fpu_b;
    rsp_data_nx    = rsp_data;
    rsp_funct_nx   = rsp_funct;
    rsp_timeout_nx = rsp_timeout;

    unique case (state)
      IDLE: begin
        if (req_valid) begin
          fpu_funct_nx = req_funct;
          fpu_a_nx     = req_a;
          fpu_b_nx     = req_b;
          rsp_funct_nx = req_funct;
          state_nx     = EXEC;
          // Fixed-latency ops count down to zero; divide counts up from zero.
          unique case (req_funct)
            F_DIV:   cnt_nx = '0;
            F_MUL:   cnt_nx = MUL_INIT;
            default: cnt_nx = ADD_INIT;
          endcase
        end
      end

      EXEC: begin
        if (fpu_funct == F_DIV) begin
          // The first EXEC cycle (cnt == 0) may still see the done flag left
          // over from the previous division, so it is not trusted there.
          // A done flag on the timeout cycle takes priority over the timeout.
          if (cnt != '0 && fpu_div_done) begin
            rsp_data_nx    = fpu_o;
            rsp_timeout_nx = 1'b0;
            cnt_nx         = '0;
            state_nx       = RESP;
          end else if (cnt == DIV_LAST) begin
            rsp_data_nx    = QNAN;
            rsp_timeout_nx = 1'b1;
            cnt_nx         = '0;
            state_nx       = RESP;
          end else begin
            cnt_nx = cnt + 8'd1;
          end
        end else begin
          if (cnt == '0) begin
            rsp_data_nx    = fpu_o;
            rsp_timeout_nx = 1'b0;
            state_nx       = RESP;
          end else begin
            cnt_nx = cnt - 8'd1;
          end
        end
      end

      RESP: begin
        if (rsp_ready) state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fpu_sequencer.sv
module tb_fpu_sequencer;

  localparam int unsigned ADD_LAT     = 2;
  localparam int unsigned MUL_LAT     = 3;
  localparam int unsigned DIV_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_funct = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [1:0]  fpu_funct;
  logic [31:0] fpu_a, fpu_b;
  logic [31:0] fpu_o = '0;
  logic        fpu_div_done = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_funct;
  logic        rsp_timeout;

  fpu_sequencer #(
    .ADD_LAT(ADD_LAT),
    .MUL_LAT(MUL_LAT),
    .DIV_TIMEOUT(DIV_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_funct(req_funct),
    .req_a(req_a),
    .req_b(req_b),
    .fpu_funct(fpu_funct),
    .fpu_a(fpu_a),
    .fpu_b(fpu_b),
    .fpu_o(fpu_o),
    .fpu_div_done(fpu_div_done),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_funct(rsp_funct),
    .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int fails = 0;
  int unexpected = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  funct;
    logic        to;
    int unsigned t;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: each new response (rising rsp_valid) is compared with the head
  // of the scoreboard, including the edge at which it appeared.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (rsp_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          unexpected++;
          $display("FAIL unexpected_rsp: got data %h funct %0d at cycle %0d, expected none",
                   rsp_data, rsp_funct, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_funct", 32'(rsp_funct), 32'(e.funct));
          check("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
          check("rsp_cycle", cyc, e.t);
        end
      end
      prev_valid = rsp_valid;
    end
  end

  // Waits for the sequencer to be ready, presents the request and returns the
  // accept edge. fo/done set the FPU model outputs for this operation.
  task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] fo, input logic done,
                       input logic [31:0] ed, input logic eto, input int unsigned lat,
                       input bit push, output int unsigned e);
    int unsigned n;
    exp_t x;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      fails++;
      $display("FAIL accept_wait: got no req_ready after %0d cycles, expected ready", n);
    end
    req_valid    = 1'b1;
    req_funct    = f;
    req_a        = a;
    req_b        = b;
    fpu_o        = fo;
    fpu_div_done = done;
    e = cyc + 1;
    if (push) begin
      x.data = ed; x.funct = f; x.to = eto; x.t = e + lat;
      sb.push_back(x);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      fails++;
      $display("FAIL drain: got %0d pending responses, expected 0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e, e2, h;
    logic [1:0]  bf [4];
    logic [31:0] ba [4];
    logic [31:0] bb [4];
    logic [31:0] bo [4];
    logic        bd [4];
    int unsigned bl [4];

    // Reset values
    #3;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("rst_fpu_a", fpu_a, 32'h0);
    check("rst_fpu_funct", 32'(fpu_funct), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Add: 1.0 + 2.0, response two edges after accept
    rsp_ready = 1'b1;
    issue(2'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 32'h40400000, 1'b0, ADD_LAT, 1, e);
    check("add_fpu_a", fpu_a, 32'h3F800000);
    check("add_fpu_b", fpu_b, 32'h40000000);
    check("add_fpu_funct", 32'(fpu_funct), 32'd0);
    check("add_req_ready_exec", 32'(req_ready), 32'd0);
    drain();

    // Div with a stale done flag at accept: the first EXEC cycle ignores it,
    // the real pulse sampled at edge E+6 is captured.
    issue(2'd2, 32'h3F800000, 32'h40000000, 32'hDEADBEEF, 1'b1, 32'h3F000000, 1'b0, 6, 1, e);
    @(negedge clk);                 // before E+1: stale flag still high
    @(negedge clk);                 // before E+2
    fpu_div_done = 1'b0;
    repeat (4) @(negedge clk);      // before E+6
    fpu_div_done = 1'b1;
    fpu_o = 32'h3F000000;
    @(negedge clk);
    fpu_div_done = 1'b0;
    drain();

    // Div timeout: quiet NaN at accept + DIV_TIMEOUT
    issue(2'd2, 32'h40000000, 32'h00000000, 32'h12345678, 1'b0, 32'h7FC00000, 1'b1, DIV_TIMEOUT, 1, e);
    drain();

    // Div done on the timeout cycle itself: done wins
    issue(2'd2, 32'h41200000, 32'h40000000, 32'h12345678, 1'b0, 32'h40A00000, 1'b0, DIV_TIMEOUT, 1, e);
    repeat (DIV_TIMEOUT) @(negedge clk);  // before E+DIV_TIMEOUT
    fpu_div_done = 1'b1;
    fpu_o = 32'h40A00000;
    @(negedge clk);
    fpu_div_done = 1'b0;
    drain();

    // Backpressure on a mul while a new request waits
    rsp_ready = 1'b0;
    issue(2'd3, 32'h40400000, 32'h40800000, 32'h41400000, 1'b0, 32'h41400000, 1'b0, MUL_LAT, 1, e);
    @(negedge clk);
    req_valid = 1'b1;
    req_funct = 2'd0;
    req_a     = 32'h3F800000;
    req_b     = 32'h3F800000;
    begin
      int unsigned n;
      n = 0;
      while (!rsp_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    fpu_o = 32'h0;
    fpu_div_done = 1'b1;            // ignored outside EXEC
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_data", rsp_data, 32'h41400000);
      check("bp_fpu_a", fpu_a, 32'h40400000);
      check("bp_fpu_b", fpu_b, 32'h40800000);
    end
    fpu_div_done = 1'b0;
    rsp_ready = 1'b1;
    h = cyc + 1;
    issue(2'd0, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 32'h40000000, 1'b0, ADD_LAT, 1, e2);
    check("bp_accept_edge", e2, h + 1);
    drain();

    // Back-to-back: add, sub, div (done held), mul
    bf = '{2'd0, 2'd1, 2'd2, 2'd3};
    ba = '{32'h3F800000, 32'h40400000, 32'h40800000, 32'h40000000};
    bb = '{32'h40000000, 32'h3F800000, 32'h40000000, 32'h40400000};
    bo = '{32'h40400000, 32'h40000000, 32'h40000000, 32'h40C00000};
    bd = '{1'b0, 1'b0, 1'b1, 1'b0};
    bl = '{ADD_LAT, ADD_LAT, 2, MUL_LAT};
    for (int i = 0; i < 4; i++) begin
      issue(bf[i], ba[i], bb[i], bo[i], bd[i], bo[i], 1'b0, bl[i], 1, e);
    end
    drain();
    fpu_div_done = 1'b0;

    // Reset in the middle of a div: state cleared, no response afterwards
    issue(2'd2, 32'h40400000, 32'h40000000, 32'h3F000000, 1'b0, 32'h0, 1'b0, 0, 0, e);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_rsp_data", rsp_data, 32'h0);
    check("mid_rst_fpu_a", fpu_a, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    fpu_div_done = 1'b1;
    repeat (30) @(negedge clk);
    fpu_div_done = 1'b0;
    check("no_unexpected_rsp", 32'(unexpected), 32'd0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + unexpected);
    $finish;
  end

endmodule
